// File: rtl/spi_baud_rate_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_baud_rate_gen
// Purpose  : SPI serial-clock generator for the APB-SPI controller. Divides
//            PCLK by the baud-rate divisor (sppr_i+1) * 2^(spr_i+1), drives
//            SCLK at the programmed CPOL idle level while stopped, and emits
//            one-PCLK strobes that tell the shift logic when to sample MISO
//            and when to launch MOSI for all four CPOL/CPHA modes.
// Ports    :
//   PCLK                 in   1   system/APB clock, rising-edge
//   PRESET_n             in   1   asynchronous active-low reset
//   spi_mode_i           in   2   00 run, 01 wait, 10/11 stop
//   spiswai_i            in   1   stop SPI clock while in wait mode
//   sppr_i               in   3   baud prescaler select
//   spr_i                in   3   baud rate select
//   cpol_i               in   1   SCLK idle level
//   cpha_i               in   1   clock phase
//   ss_i                 in   1   slave select, active-low
//   sclk_o               out  1   SPI serial clock
//   miso_receive_sclk_o  out  1   sample MISO at coming SCLK rising edge
//   miso_receive_sclk0_o out  1   sample MISO at coming SCLK falling edge
//   mosi_send_sclk_o     out  1   launch MOSI at coming SCLK rising edge
//   mosi_send_sclk0_o    out  1   launch MOSI at coming SCLK falling edge
//   BaudRateDivisor_o    out  12  PCLK cycles per full SCLK period
// Revision : 1.0 - initial release
// ============================================================================
module spi_baud_rate_gen (
    input  logic        PCLK,
    input  logic        PRESET_n,
    input  logic [1:0]  spi_mode_i,
    input  logic        spiswai_i,
    input  logic [2:0]  sppr_i,
    input  logic [2:0]  spr_i,
    input  logic        cpol_i,
    input  logic        cpha_i,
    input  logic        ss_i,
    output logic        sclk_o,
    output logic        miso_receive_sclk_o,
    output logic        miso_receive_sclk0_o,
    output logic        mosi_send_sclk_o,
    output logic        mosi_send_sclk0_o,
    output logic [11:0] BaudRateDivisor_o
);

    localparam int c_CNT_W = 12;

    logic [3:0]         w_shift;
    logic [11:0]        w_sppr_p1;
    logic [11:0]        w_divisor;
    logic [c_CNT_W-1:0] w_half_m1;
    logic               w_enable;
    logic               w_at_compare;
    logic               w_mode_sel;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic               w_sclk_nxt;
    logic               w_strobe;
    logic               w_rise;
    logic               w_fall;

    logic [c_CNT_W-1:0] r_count;
    logic               r_sclk;
    logic               r_miso_rx_rise;
    logic               r_miso_rx_fall;
    logic               r_mosi_tx_rise;
    logic               r_mosi_tx_fall;

    // Divisor ranges 2..2048, so 12 bits never overflow.
    assign w_shift   = {1'b0, spr_i} + 4'd1;
    assign w_sppr_p1 = {9'd0, sppr_i} + 12'd1;
    assign w_divisor = w_sppr_p1 << w_shift;
    assign w_half_m1 = (w_divisor >> 1) - 12'd1;

    assign BaudRateDivisor_o = w_divisor;

    assign w_enable = ~ss_i & ((spi_mode_i == 2'b00) |
                               ((spi_mode_i == 2'b01) & ~spiswai_i));

    // Greater-or-equal rather than equality: if the divisor shrinks while the
    // counter is already past the new half period, the next compare still
    // fires immediately instead of wrapping through the whole counter range.
    assign w_at_compare = (r_count >= w_half_m1);

    // Modes 0 and 3 sample on rising edges; modes 1 and 2 on falling edges.
    assign w_mode_sel = cpol_i ~^ cpha_i;

    always_comb begin
        w_count_nxt = '0;
        w_sclk_nxt  = cpol_i;
        if (w_enable) begin
            if (w_at_compare) begin
                w_count_nxt = '0;
                w_sclk_nxt  = ~r_sclk;
            end else begin
                w_count_nxt = r_count + 12'd1;
                w_sclk_nxt  = r_sclk;
            end
        end
    end

    // Strobes are registered from the next-state values so that each one is
    // high exactly in the cycle where the counter sits at H-1, one PCLK ahead
    // of the SCLK edge it announces. The edge direction follows the SCLK
    // level held during that cycle.
    assign w_strobe = w_enable & (w_count_nxt == w_half_m1);
    assign w_rise   = w_strobe & ~w_sclk_nxt;
    assign w_fall   = w_strobe &  w_sclk_nxt;

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_count        <= '0;
            r_sclk         <= 1'b0;
            r_miso_rx_rise <= 1'b0;
            r_miso_rx_fall <= 1'b0;
            r_mosi_tx_rise <= 1'b0;
            r_mosi_tx_fall <= 1'b0;
        end else begin
            r_count        <= w_count_nxt;
            r_sclk         <= w_sclk_nxt;
            r_miso_rx_rise <= w_rise &  w_mode_sel;
            r_mosi_tx_fall <= w_fall &  w_mode_sel;
            r_miso_rx_fall <= w_fall & ~w_mode_sel;
            r_mosi_tx_rise <= w_rise & ~w_mode_sel;
        end
    end

    assign sclk_o               = r_sclk;
    assign miso_receive_sclk_o  = r_miso_rx_rise;
    assign miso_receive_sclk0_o = r_miso_rx_fall;
    assign mosi_send_sclk_o     = r_mosi_tx_rise;
    assign mosi_send_sclk0_o    = r_mosi_tx_fall;

endmodule
`default_nettype wire

// File: tb/tb_spi_baud_rate_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_baud_rate_gen
// Purpose  : Directed self-checking bench for spi_baud_rate_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_baud_rate_gen;

    logic        PCLK;
    logic        PRESET_n;
    logic [1:0]  spi_mode_i;
    logic        spiswai_i;
    logic [2:0]  sppr_i;
    logic [2:0]  spr_i;
    logic        cpol_i;
    logic        cpha_i;
    logic        ss_i;
    logic        sclk_o;
    logic        miso_receive_sclk_o;
    logic        miso_receive_sclk0_o;
    logic        mosi_send_sclk_o;
    logic        mosi_send_sclk0_o;
    logic [11:0] BaudRateDivisor_o;

    int total = 0;
    int bad   = 0;

    spi_baud_rate_gen dut (
        .PCLK                 (PCLK),
        .PRESET_n             (PRESET_n),
        .spi_mode_i           (spi_mode_i),
        .spiswai_i            (spiswai_i),
        .sppr_i               (sppr_i),
        .spr_i                (spr_i),
        .cpol_i               (cpol_i),
        .cpha_i               (cpha_i),
        .ss_i                 (ss_i),
        .sclk_o               (sclk_o),
        .miso_receive_sclk_o  (miso_receive_sclk_o),
        .miso_receive_sclk0_o (miso_receive_sclk0_o),
        .mosi_send_sclk_o     (mosi_send_sclk_o),
        .mosi_send_sclk0_o    (mosi_send_sclk0_o),
        .BaudRateDivisor_o    (BaudRateDivisor_o)
    );

    initial begin
        PCLK = 1'b0;
        forever #10 PCLK = ~PCLK;
    end

    // Strobe vector order: {miso_rise, miso_fall, mosi_rise, mosi_fall}
    function automatic logic [3:0] strobes();
        return {miso_receive_sclk_o, miso_receive_sclk0_o,
                mosi_send_sclk_o, mosi_send_sclk0_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Park the block stopped with a new configuration, confirm the idle
    // level, then drop ss_i so the next edge is enabled edge number 1.
    task automatic start(input logic [2:0] p, input logic [2:0] r,
                         input logic pol, input logic pha);
        ss_i       = 1'b1;
        spi_mode_i = 2'b00;
        spiswai_i  = 1'b0;
        sppr_i     = p;
        spr_i      = r;
        cpol_i     = pol;
        cpha_i     = pha;
        tick();
        chk("idle_sclk", {31'd0, sclk_o}, {31'd0, pol});
        chk("idle_strobes", {28'd0, strobes()}, 32'd0);
        ss_i = 1'b0;
    endtask

    // After enabled edge k: counter = k mod H, SCLK has toggled floor(k/H)
    // times, and a strobe is up when the counter sits at H-1.
    task automatic run_check(input string tag, input int h, input logic pol,
                             input logic m, input int ncyc);
        logic       exp_sclk;
        logic [3:0] exp_str;
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            exp_sclk = pol ^ logic'((k / h) % 2);
            exp_str  = 4'b0000;
            if (((k + 1) % h) == 0) begin
                if (!exp_sclk) exp_str = m ? 4'b1000 : 4'b0010;
                else           exp_str = m ? 4'b0001 : 4'b0100;
            end
            chk({tag, "_sclk"}, {31'd0, sclk_o}, {31'd0, exp_sclk});
            chk({tag, "_strobes"}, {28'd0, strobes()}, {28'd0, exp_str});
        end
    endtask

    task automatic wait_toggle(output int n);
        logic prev;
        prev = sclk_o;
        n = 0;
        while (n < 4096) begin
            tick();
            n++;
            if (sclk_o !== prev) break;
        end
    endtask

    task automatic sweep(input logic [2:0] p, input logic [2:0] r, input int d);
        int n1, n2, n3;
        start(p, r, 1'b0, 1'b0);
        chk("sweep_divisor", {20'd0, BaudRateDivisor_o}, d);
        wait_toggle(n1);
        chk("sweep_first_edge", n1, d / 2);
        wait_toggle(n2);
        wait_toggle(n3);
        chk("sweep_period", n2 + n3, d);
    endtask

    initial begin
        PRESET_n   = 1'b0;
        ss_i       = 1'b1;
        spi_mode_i = 2'b00;
        spiswai_i  = 1'b0;
        sppr_i     = 3'd0;
        spr_i      = 3'd1;
        cpol_i     = 1'b1;
        cpha_i     = 1'b1;

        // Reset: outputs low regardless of CPOL, divisor is combinational
        #25;
        chk("rst_sclk", {31'd0, sclk_o}, 32'd0);
        chk("rst_strobes", {28'd0, strobes()}, 32'd0);
        chk("rst_divisor", {20'd0, BaudRateDivisor_o}, 32'd4);
        PRESET_n = 1'b1;
        tick();
        chk("rel_sclk_cpol", {31'd0, sclk_o}, 32'd1);
        chk("rel_strobes", {28'd0, strobes()}, 32'd0);

        // Mode 3, D=4
        start(3'd0, 3'd1, 1'b1, 1'b1);
        run_check("mode3", 2, 1'b1, 1'b1, 12);
        // Mode 0
        start(3'd0, 3'd1, 1'b0, 1'b0);
        run_check("mode0", 2, 1'b0, 1'b1, 12);
        // Mode 2
        start(3'd0, 3'd1, 1'b1, 1'b0);
        run_check("mode2", 2, 1'b1, 1'b0, 12);
        // Mode 1
        start(3'd0, 3'd1, 1'b0, 1'b1);
        run_check("mode1", 2, 1'b0, 1'b0, 12);
        // H=1: toggles every PCLK, strobes alternate
        start(3'd0, 3'd0, 1'b0, 1'b0);
        chk("h1_divisor", {20'd0, BaudRateDivisor_o}, 32'd2);
        run_check("h1", 1, 1'b0, 1'b1, 6);
        // Larger H with idle-high CPOL
        start(3'd2, 3'd0, 1'b1, 1'b1);
        chk("h3_divisor", {20'd0, BaudRateDivisor_o}, 32'd6);
        run_check("h3", 3, 1'b1, 1'b1, 14);

        // Wait mode with spiswai=1: frozen
        start(3'd0, 3'd1, 1'b0, 1'b0);
        spi_mode_i = 2'b01;
        spiswai_i  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("wait_frozen_sclk", {31'd0, sclk_o}, 32'd0);
            chk("wait_frozen_strobes", {28'd0, strobes()}, 32'd0);
        end
        spiswai_i = 1'b0;
        run_check("wait_run", 2, 1'b0, 1'b1, 6);
        // Stop mode mid-transfer (SCLK currently high)
        spi_mode_i = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stop_sclk", {31'd0, sclk_o}, 32'd0);
            chk("stop_strobes", {28'd0, strobes()}, 32'd0);
        end
        spi_mode_i = 2'b00;
        run_check("rerun", 2, 1'b0, 1'b1, 6);
        // ss_i rising mid-transfer (SCLK currently high)
        ss_i = 1'b1;
        tick();
        chk("ss_stop_sclk", {31'd0, sclk_o}, 32'd0);
        chk("ss_stop_strobes", {28'd0, strobes()}, 32'd0);

        // Asynchronous reset mid-transfer with CPOL=1
        start(3'd0, 3'd1, 1'b1, 1'b1);
        run_check("pre_rst", 2, 1'b1, 1'b1, 3);
        #3;
        PRESET_n = 1'b0;
        #1;
        chk("async_rst_sclk", {31'd0, sclk_o}, 32'd0);
        chk("async_rst_strobes", {28'd0, strobes()}, 32'd0);
        #5;
        ss_i     = 1'b1;
        PRESET_n = 1'b1;
        tick();
        chk("rel2_sclk_cpol", {31'd0, sclk_o}, 32'd1);

        // Divisor sweep
        sweep(3'd0, 3'd0, 2);
        sweep(3'd2, 3'd3, 48);
        sweep(3'd7, 3'd7, 2048);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
